// File: rtl/ad9767_seq.sv
// AD9767 dual-channel DAC sequencer: divided DAC clock plus round-robin A/B sample arbitration.
// Optional build macro AD9767_SEQ_MIDSCALE_EN: reset and empty update slots drive midscale 14'h2000.
module ad9767_seq #(
    parameter int unsigned DIV_HALF = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [13:0] i_a_data,
    input  logic [13:0] i_b_data,
    input  logic        i_a_valid,
    input  logic        i_b_valid,
    output logic        o_a_ready,
    output logic        o_b_ready,
    output logic        o_dac_clk,
    output logic [13:0] o_dac_data,
    output logic        o_dac_sel,
    output logic [7:0]  o_underflow_cnt
);

    localparam logic [3:0] CNT_MAX = 4'(DIV_HALF - 1);
`ifdef AD9767_SEQ_MIDSCALE_EN
    localparam logic [13:0] IDLE_DATA = 14'h2000;
`else
    localparam logic [13:0] IDLE_DATA = 14'h0000;
`endif

    logic [3:0]  cnt_q, cnt_d;
    logic        dac_clk_q, dac_clk_d;
    logic [13:0] data_q, data_d;
    logic        sel_q, sel_d;
    logic        last_a_q, last_a_d;
    logic [7:0]  unf_q, unf_d;

    logic cnt_wrap;
    logic update;
    logic grant_a;
    logic grant_b;

    // Update on the last cycle of the DAC clock high phase, so new data
    // lands with the falling edge and is settled for the next rising edge.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_MAX);
        update   = i_enable && !i_rst && dac_clk_q && cnt_wrap;
        grant_a  = update && i_a_valid && (!i_b_valid || !last_a_q);
        grant_b  = update && i_b_valid && (!i_a_valid || last_a_q);
    end

    always_comb begin
        cnt_d     = cnt_q;
        dac_clk_d = dac_clk_q;
        data_d    = data_q;
        sel_d     = sel_q;
        last_a_d  = last_a_q;
        unf_d     = unf_q;

        if (!i_enable) begin
            cnt_d     = 4'd0;
            dac_clk_d = 1'b0;
        end else if (cnt_wrap) begin
            cnt_d     = 4'd0;
            dac_clk_d = !dac_clk_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end

        if (grant_a) begin
            data_d   = i_a_data;
            sel_d    = 1'b1;
            last_a_d = 1'b1;
        end else if (grant_b) begin
            data_d   = i_b_data;
            sel_d    = 1'b0;
            last_a_d = 1'b0;
        end else if (update) begin
            if (unf_q != 8'hFF) begin
                unf_d = unf_q + 8'd1;
            end
`ifdef AD9767_SEQ_MIDSCALE_EN
            data_d = IDLE_DATA;
`endif
        end
    end

    // last_a_q cleared on reset means B counts as last granted, so A wins first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= 4'd0;
            dac_clk_q <= 1'b0;
            data_q    <= IDLE_DATA;
            sel_q     <= 1'b0;
            last_a_q  <= 1'b0;
            unf_q     <= 8'd0;
        end else begin
            cnt_q     <= cnt_d;
            dac_clk_q <= dac_clk_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            last_a_q  <= last_a_d;
            unf_q     <= unf_d;
        end
    end

    assign o_a_ready       = grant_a;
    assign o_b_ready       = grant_b;
    assign o_dac_clk       = dac_clk_q;
    assign o_dac_data      = data_q;
    assign o_dac_sel       = sel_q;
    assign o_underflow_cnt = unf_q;

endmodule

// File: tb/tb_ad9767_seq.sv
// Bench for ad9767_seq: phase-based reference model feeding an output scoreboard.
module tb_ad9767_seq;

    localparam int DH = 4;
`ifdef AD9767_SEQ_MIDSCALE_EN
    localparam logic [13:0] RST_DATA = 14'h2000;
    localparam bit MID = 1'b1;
`else
    localparam logic [13:0] RST_DATA = 14'h0000;
    localparam bit MID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [13:0] a_dat = '0, b_dat = '0;
    logic        a_vld = 1'b0, b_vld = 1'b0;
    logic        a_rdy, b_rdy, dac_clk, dac_sel;
    logic [13:0] dac_data;
    logic [7:0]  unf_cnt;

    always #5 clk = ~clk;

    ad9767_seq #(.DIV_HALF(DH)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_a_data(a_dat), .i_b_data(b_dat),
        .i_a_valid(a_vld), .i_b_valid(b_vld),
        .o_a_ready(a_rdy), .o_b_ready(b_rdy),
        .o_dac_clk(dac_clk), .o_dac_data(dac_data),
        .o_dac_sel(dac_sel), .o_underflow_cnt(unf_cnt)
    );

    typedef struct packed {
        logic [13:0] data;
        logic        sel;
    } out_t;

    out_t sb[$];

    // Model state: e = enabled edges since reset/disable, which fixes the DAC clock phase.
    int          e = 0;
    bit          m_last_a = 1'b0;
    int          m_unf = 0;
    logic [13:0] m_data = RST_DATA;
    logic        m_sel = 1'b0;

    logic exp_ra, exp_rb, exp_clk, obs_ra, obs_rb, obs_clk, obs_clk_post;
    out_t exp_out;
    logic [13:0] obs_data;
    logic        obs_sel;
    logic [7:0]  obs_unf;

    int pass_cnt = 0;
    int check_cnt = 0;

    task automatic tick();
        bit upd, ga, gb;
        @(negedge clk);
        upd = en && !rst && ((e % (2*DH)) == 2*DH-1);
        ga  = upd && a_vld && (!b_vld || !m_last_a);
        gb  = upd && b_vld && (!a_vld || m_last_a);
        exp_ra  = ga;
        exp_rb  = gb;
        exp_clk = ((e / DH) % 2) == 1;
        obs_ra  = a_rdy;
        obs_rb  = b_rdy;
        obs_clk = dac_clk;
        if (rst) begin
            m_data = RST_DATA; m_sel = 1'b0; m_last_a = 1'b0; m_unf = 0; e = 0;
        end else begin
            if (ga) begin
                m_data = a_dat; m_sel = 1'b1; m_last_a = 1'b1;
            end else if (gb) begin
                m_data = b_dat; m_sel = 1'b0; m_last_a = 1'b0;
            end else if (upd) begin
                if (m_unf < 255) m_unf++;
                if (MID) m_data = 14'h2000;
            end
            e = en ? e + 1 : 0;
        end
        sb.push_back({m_data, m_sel});
        @(posedge clk);
        #1;
        exp_out      = sb.pop_front();
        obs_data     = dac_data;
        obs_sel      = dac_sel;
        obs_unf      = unf_cnt;
        obs_clk_post = dac_clk;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; a_vld = 1'b1; b_vld = 1'b1;
        tick();
        tick();
        check_cnt++; if (obs_ra !== 1'b0 || obs_rb !== 1'b0) $display("FAIL reset_ready got a=%b b=%b want 0 0", obs_ra, obs_rb); else pass_cnt++;
        check_cnt++; if (obs_clk_post !== 1'b0) $display("FAIL reset_clk got %b want 0", obs_clk_post); else pass_cnt++;
        check_cnt++; if (obs_data !== RST_DATA) $display("FAIL reset_data got %h want %h", obs_data, RST_DATA); else pass_cnt++;
        check_cnt++; if (obs_sel !== 1'b0) $display("FAIL reset_sel got %b want 0", obs_sel); else pass_cnt++;
        check_cnt++; if (obs_unf !== 8'd0) $display("FAIL reset_unf got %0d want 0", obs_unf); else pass_cnt++;
        rst = 1'b0; en = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    endtask

    task automatic test_clk_timing();
        int rise1, fall1, rise2;
        logic prev;
        rise1 = -1; fall1 = -1; rise2 = -1;
        do_reset();
        en = 1'b1;
        prev = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            check_cnt++; if (obs_clk !== exp_clk) $display("FAIL clk_phase t=%0d got %b want %b", i, obs_clk, exp_clk); else pass_cnt++;
            if (obs_clk_post === 1'b1 && prev === 1'b0) begin
                if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i;
            end
            if (obs_clk_post === 1'b0 && prev === 1'b1 && fall1 < 0) fall1 = i;
            prev = obs_clk_post;
        end
        check_cnt++; if (rise1 !== 4) $display("FAIL clk_first_rise got %0d want 4", rise1); else pass_cnt++;
        check_cnt++; if (fall1 !== 8) $display("FAIL clk_first_fall got %0d want 8", fall1); else pass_cnt++;
        check_cnt++; if (rise2 !== 12) $display("FAIL clk_period got rise2 %0d want 12", rise2); else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_alternate();
        bit want_a;
        int n_grants;
        want_a = 1'b1; n_grants = 0;
        do_reset();
        en = 1'b1; a_vld = 1'b1; b_vld = 1'b1; a_dat = 14'h1111; b_dat = 14'h2222;
        for (int i = 1; i <= 48; i++) begin
            tick();
            check_cnt++; if (obs_ra !== exp_ra || obs_rb !== exp_rb) $display("FAIL alt_ready t=%0d got %b%b want %b%b", i, obs_ra, obs_rb, exp_ra, exp_rb); else pass_cnt++;
            check_cnt++; if (obs_data !== exp_out.data || obs_sel !== exp_out.sel) $display("FAIL alt_data t=%0d got %h/%b want %h/%b", i, obs_data, obs_sel, exp_out.data, exp_out.sel); else pass_cnt++;
            if (obs_ra === 1'b1 || obs_rb === 1'b1) begin
                n_grants++;
                check_cnt++; if (obs_ra !== want_a || obs_rb === obs_ra) $display("FAIL alt_order t=%0d got a=%b b=%b want a=%b", i, obs_ra, obs_rb, want_a); else pass_cnt++;
                want_a = !want_a;
            end
        end
        check_cnt++; if (n_grants !== 6) $display("FAIL alt_grant_count got %0d want 6", n_grants); else pass_cnt++;
        en = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    endtask

    task automatic test_only_b();
        do_reset();
        en = 1'b1; b_vld = 1'b1; b_dat = 14'h3FFF; a_dat = 14'h0555;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check_cnt++; if (obs_ra !== 1'b0 || obs_rb !== exp_rb) $display("FAIL onlyb_ready t=%0d got %b%b want 0%b", i, obs_ra, obs_rb, exp_rb); else pass_cnt++;
            check_cnt++; if (obs_data !== exp_out.data || obs_sel !== exp_out.sel) $display("FAIL onlyb_data t=%0d got %h/%b want %h/%b", i, obs_data, obs_sel, exp_out.data, exp_out.sel); else pass_cnt++;
            check_cnt++; if (obs_unf !== 8'd0) $display("FAIL onlyb_unf t=%0d got %0d want 0", i, obs_unf); else pass_cnt++;
        end
        check_cnt++; if (obs_data !== 14'h3FFF || obs_sel !== 1'b0) $display("FAIL onlyb_final got %h/%b want 3fff/0", obs_data, obs_sel); else pass_cnt++;
        en = 1'b0; b_vld = 1'b0;
    endtask

    task automatic test_underflow();
        logic [13:0] want_hold;
        want_hold = MID ? 14'h2000 : 14'h0ABC;
        do_reset();
        en = 1'b1; a_vld = 1'b1; a_dat = 14'h0ABC;
        for (int k = 0; k < 20 && !(obs_ra === 1'b1); k++) tick();
        a_vld = 1'b0;
        for (int i = 1; i <= 300*2*DH; i++) begin
            tick();
            check_cnt++; if (obs_unf !== 8'(exp_clk ? m_unf : m_unf)) $display("FAIL unf_count t=%0d got %0d want %0d", i, obs_unf, m_unf); else pass_cnt++;
        end
        check_cnt++; if (obs_unf !== 8'd255) $display("FAIL unf_saturate got %0d want 255", obs_unf); else pass_cnt++;
        check_cnt++; if (obs_data !== want_hold || obs_sel !== 1'b1) $display("FAIL unf_hold got %h/%b want %h/1", obs_data, obs_sel, want_hold); else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_disable();
        int lat;
        lat = -1;
        do_reset();
        en = 1'b1; a_vld = 1'b1; a_dat = 14'h1234;
        for (int k = 0; k < 20 && (e % (2*DH)) != 6; k++) tick();
        en = 1'b0;
        tick();
        check_cnt++; if (obs_clk_post !== 1'b0) $display("FAIL dis_clk got %b want 0", obs_clk_post); else pass_cnt++;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_cnt++; if (obs_ra !== 1'b0 || obs_clk_post !== 1'b0) $display("FAIL dis_quiet t=%0d got rdy=%b clk=%b want 0 0", i, obs_ra, obs_clk_post); else pass_cnt++;
            check_cnt++; if (obs_data !== exp_out.data || obs_unf !== 8'(m_unf)) $display("FAIL dis_hold t=%0d got %h/%0d want %h/%0d", i, obs_data, obs_unf, exp_out.data, m_unf); else pass_cnt++;
        end
        en = 1'b1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            if (obs_ra === 1'b1) lat = i;
        end
        check_cnt++; if (lat !== 2*DH) $display("FAIL dis_reenable_latency got %0d want %0d", lat, 2*DH); else pass_cnt++;
        check_cnt++; if (obs_data !== 14'h1234 || obs_sel !== 1'b1) $display("FAIL dis_reenable_data got %h/%b want 1234/1", obs_data, obs_sel); else pass_cnt++;
        en = 1'b0; a_vld = 1'b0;
    endtask

    task automatic test_reset_mid();
        int first;
        first = -1;
        do_reset();
        en = 1'b1; a_vld = 1'b1; b_vld = 1'b1; a_dat = 14'h0AAA; b_dat = 14'h0BBB;
        for (int k = 0; k < 40 && (e % (2*DH)) != 2*DH-1; k++) tick();
        for (int k = 0; k < 20 && (e % (2*DH)) != 2*DH-1 || k == 0; k++) tick();
        rst = 1'b1;
        tick();
        check_cnt++; if (obs_ra !== 1'b0 || obs_rb !== 1'b0) $display("FAIL rstmid_ready got %b%b want 00", obs_ra, obs_rb); else pass_cnt++;
        check_cnt++; if (obs_data !== RST_DATA || obs_sel !== 1'b0 || obs_unf !== 8'd0 || obs_clk_post !== 1'b0) $display("FAIL rstmid_outputs got %h/%b/%0d/%b want %h/0/0/0", obs_data, obs_sel, obs_unf, obs_clk_post, RST_DATA); else pass_cnt++;
        rst = 1'b0;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            tick();
            if (obs_ra === 1'b1) first = 1; else if (obs_rb === 1'b1) first = 0;
        end
        check_cnt++; if (first !== 1) $display("FAIL rstmid_first_grant got %0d want 1", first); else pass_cnt++;
        en = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            a_vld = 1'($urandom_range(0, 1)); b_vld = 1'($urandom_range(0, 1));
            a_dat = 14'($urandom); b_dat = 14'($urandom);
            if ((i % 97) == 0) en = 1'b0; else if ((i % 97) == 5) en = 1'b1;
            tick();
            check_cnt++; if (obs_ra !== exp_ra || obs_rb !== exp_rb || (obs_ra & obs_rb)) $display("FAIL rnd_ready t=%0d got %b%b want %b%b", i, obs_ra, obs_rb, exp_ra, exp_rb); else pass_cnt++;
            check_cnt++; if (obs_data !== exp_out.data || obs_sel !== exp_out.sel || obs_unf !== 8'(m_unf)) $display("FAIL rnd_out t=%0d got %h/%b/%0d want %h/%b/%0d", i, obs_data, obs_sel, obs_unf, exp_out.data, exp_out.sel, m_unf); else pass_cnt++;
        end
        en = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clk_timing();
        test_alternate();
        test_only_b();
        test_underflow();
        test_disable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
